// File: rtl/shader_pkg.sv
// Shared constants and types for the shader sequencer slice.
package shader_pkg;

  localparam int NUM_INSTR      = 12;
  localparam int WIDTH          = 640;
  localparam int HEIGHT         = 480;
  localparam int X_SMALL        = WIDTH / NUM_INSTR;
  localparam int Y_SMALL        = HEIGHT / NUM_INSTR;
  localparam int SUB_W          = $clog2(NUM_INSTR);
  localparam int X_W            = $clog2(X_SMALL);
  localparam int Y_W            = $clog2(Y_SMALL);
  localparam int INSTR_W        = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } seq_state_e;

endpackage

// File: rtl/shader_wr_fifo.sv
// Small synchronous show-ahead FIFO holding SPI instruction writes until the
// sequencer has an idle cycle to apply them. DEPTH must be a power of 2.
module shader_wr_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is fine then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/shader_sequencer.sv
// Shader sequencer: runs one program rotation per coarse pixel, applies queued
// SPI program writes only between slots, and tracks coarse x/y coordinates.
// Optional build macro SHADER_SEQ_DROP_CNT_EN adds an 8-bit saturating
// dropped-write counter on drop_cnt_o.
//
// state | meaning
// IDLE  | no slot running; queued writes may be loaded when run_i is low
// EXEC  | slot running; executes and rotates memory for NUM_INSTR cycles
module shader_sequencer
  import shader_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               run_i,
  input  logic               line_vis_i,
  input  logic               next_line_i,
  input  logic               next_frame_i,
  input  logic               wr_valid_i,
  input  logic [INSTR_W-1:0] wr_instr_i,
  output logic               mem_shift_o,
  output logic               mem_load_o,
  output logic [INSTR_W-1:0] mem_instr_o,
  output logic               exec_o,
  output logic               capture_o,
  output logic [SUB_W-1:0]   x_subpos_o,
  output logic [X_W-1:0]     x_pos_o,
  output logic [Y_W-1:0]     y_pos_o,
`ifdef SHADER_SEQ_DROP_CNT_EN
  output logic [7:0]         drop_cnt_o,
`endif
  output logic               overflow_o
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(NUM_INSTR - 1);
  localparam logic [SUB_W-1:0] SUB_PREV = SUB_W'(NUM_INSTR - 2);

  seq_state_e         state_q;
  logic [SUB_W-1:0]   y_sub_q;
  logic [INSTR_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               drop;

  // run_i in IDLE takes priority over a pending write so pixel timing never slips.
  assign pop  = (state_q == IDLE) && !run_i && !fifo_empty;
  assign push = wr_valid_i && (!fifo_full || pop);
  assign drop = wr_valid_i && fifo_full && !pop;

  shader_wr_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (INSTR_W)
  ) u_wr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_instr_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Slot sequencing FSM with registered memory/execute controls and coarse x.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      exec_o      <= 1'b0;
      mem_shift_o <= 1'b0;
      mem_load_o  <= 1'b0;
      mem_instr_o <= '0;
      capture_o   <= 1'b0;
      x_subpos_o  <= '0;
      x_pos_o     <= '0;
    end else begin
      mem_load_o  <= 1'b0;
      mem_instr_o <= '0;
      capture_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run_i) begin
            state_q     <= EXEC;
            exec_o      <= 1'b1;
            mem_shift_o <= 1'b1;
            x_subpos_o  <= '0;
          end else if (pop) begin
            exec_o      <= 1'b0;
            mem_shift_o <= 1'b1;
            mem_load_o  <= 1'b1;
            mem_instr_o <= fifo_head;
          end else begin
            exec_o      <= 1'b0;
            mem_shift_o <= 1'b0;
          end
        end
        EXEC: begin
          if (x_subpos_o == SUB_LAST) begin
            x_subpos_o <= '0;
            if (!run_i) begin
              state_q     <= IDLE;
              exec_o      <= 1'b0;
              mem_shift_o <= 1'b0;
            end
          end else begin
            x_subpos_o <= x_subpos_o + SUB_W'(1);
            capture_o  <= (x_subpos_o == SUB_PREV);
          end
        end
      endcase
      if (next_line_i) begin
        x_pos_o <= '0;
      end else if (state_q == EXEC && x_subpos_o == SUB_LAST) begin
        x_pos_o <= x_pos_o + X_W'(1);
      end
    end
  end

  // Coarse y: advances once every NUM_INSTR visible lines.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_pos_o <= '0;
      y_sub_q <= '0;
    end else if (next_frame_i) begin
      y_pos_o <= '0;
      y_sub_q <= '0;
    end else if (next_line_i && line_vis_i) begin
      if (y_sub_q == SUB_LAST) begin
        y_sub_q <= '0;
        y_pos_o <= y_pos_o + Y_W'(1);
      end else begin
        y_sub_q <= y_sub_q + SUB_W'(1);
      end
    end
  end

  // Sticky per-frame loss flag; a drop in the frame-boundary cycle still sets it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end else if (next_frame_i) begin
      overflow_o <= 1'b0;
    end
  end

`ifdef SHADER_SEQ_DROP_CNT_EN
  // Lifetime count of dropped writes, saturating at 255.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_o <= '0;
    end else if (drop && drop_cnt_o != 8'hFF) begin
      drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shader_sequencer.sv
// Self-checking bench for shader_sequencer: expected program loads are queued
// when writes are driven and matched when the DUT loads memory.
module tb_shader_sequencer;
  import shader_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               run_i, line_vis_i, next_line_i, next_frame_i, wr_valid_i;
  logic [INSTR_W-1:0] wr_instr_i;
  logic               mem_shift_o, mem_load_o, exec_o, capture_o, overflow_o;
  logic [INSTR_W-1:0] mem_instr_o;
  logic [SUB_W-1:0]   x_subpos_o;
  logic [X_W-1:0]     x_pos_o;
  logic [Y_W-1:0]     y_pos_o;
`ifdef SHADER_SEQ_DROP_CNT_EN
  logic [7:0]         drop_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [INSTR_W-1:0] load_q [$];

  always #5 clk_i = ~clk_i;

  shader_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .run_i        (run_i),
    .line_vis_i   (line_vis_i),
    .next_line_i  (next_line_i),
    .next_frame_i (next_frame_i),
    .wr_valid_i   (wr_valid_i),
    .wr_instr_i   (wr_instr_i),
    .mem_shift_o  (mem_shift_o),
    .mem_load_o   (mem_load_o),
    .mem_instr_o  (mem_instr_o),
    .exec_o       (exec_o),
    .capture_o    (capture_o),
    .x_subpos_o   (x_subpos_o),
    .x_pos_o      (x_pos_o),
    .y_pos_o      (y_pos_o),
`ifdef SHADER_SEQ_DROP_CNT_EN
    .drop_cnt_o   (drop_cnt_o),
`endif
    .overflow_o   (overflow_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_line(input logic vis);
    line_vis_i  = vis;
    next_line_i = 1'b1;
    tick();
    next_line_i = 1'b0;
  endtask

  task automatic pulse_frame();
    next_frame_i = 1'b1;
    tick();
    next_frame_i = 1'b0;
  endtask

  // One write per cycle; accepted writes become expected loads.
  task automatic write(input logic [7:0] b, input logic accept);
    wr_valid_i = 1'b1;
    wr_instr_i = b;
    if (accept) load_q.push_back(b);
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (exec_o && n < 30) begin
      tick();
      n++;
    end
    check_val(tag, exec_o, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (load_q.size() != 0 && n < 80) begin
      tick();
      n++;
    end
    tick();
    check_val(tag, load_q.size(), 0);
  endtask

  // Load scoreboard and per-cycle protocol checks.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (mem_load_o) begin
        if (load_q.size() == 0) begin
          check_val("load_unexpected", 1, 0);
        end else begin
          check_val("load_instr", mem_instr_o, load_q.pop_front());
          check_val("load_not_in_exec", exec_o, 0);
          check_val("load_shift", mem_shift_o, 1);
        end
      end else if (mem_instr_o != '0) begin
        check_val("instr_zero_no_load", mem_instr_o, 0);
      end
      if (capture_o) check_val("capture_subpos", x_subpos_o, NUM_INSTR - 1);
    end
  end

  initial begin
    int n_exec, n_cap, t_fall, t_load, c1, c2, n;
    logic prev;
    rst_ni = 1'b0; run_i = 1'b0; line_vis_i = 1'b0; next_line_i = 1'b0;
    next_frame_i = 1'b0; wr_valid_i = 1'b0; wr_instr_i = '0;
    #12;
    check_val("rst_exec", exec_o, 0);
    check_val("rst_shift", mem_shift_o, 0);
    check_val("rst_load", mem_load_o, 0);
    check_val("rst_xpos", x_pos_o, 0);
    check_val("rst_ypos", y_pos_o, 0);
    check_val("rst_ovf", overflow_o, 0);
    tick();
    rst_ni = 1'b1;

    // Reset in the middle of a slot.
    run_i = 1'b1; tick(); run_i = 1'b0;
    n = 0;
    while (x_subpos_o != 5 && n < 20) begin tick(); n++; end
    check_val("mid_sub5_reached", x_subpos_o, 5);
    #2 rst_ni = 1'b0;
    #1;
    check_val("midrst_exec", exec_o, 0);
    check_val("midrst_shift", mem_shift_o, 0);
    check_val("midrst_sub", x_subpos_o, 0);
    check_val("midrst_cap", capture_o, 0);
    #2 rst_ni = 1'b1;
    tick();
    run_i = 1'b1; tick(); run_i = 1'b0;
    check_val("restart_exec", exec_o, 1);
    check_val("restart_sub", x_subpos_o, 0);
    wait_idle("restart_idle");

    // Two back-to-back slots.
    pulse_line(1'b0);
    check_val("xpos_line_clr", x_pos_o, 0);
    n_exec = 0; c1 = -1; c2 = -1;
    run_i = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (exec_o) n_exec++;
      if (capture_o) begin if (c1 < 0) c1 = i; else c2 = i; end
      if (i == 12) check_val("xpos_at_cap1", x_pos_o, 0);
      if (i == 13) check_val("xpos_after_cap1", x_pos_o, 1);
    end
    run_i = 1'b0;
    tick();
    check_val("run24_exec_cnt", n_exec, 24);
    check_val("run24_cap1", c1, 12);
    check_val("run24_cap2", c2, 24);
    check_val("run24_end_exec", exec_o, 0);
    check_val("run24_xpos", x_pos_o, 2);

    // run_i drops early; slot still completes.
    pulse_line(1'b0);
    n_exec = 0; n_cap = 0;
    run_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 2) run_i = 1'b0;
      if (exec_o) n_exec++;
      if (capture_o) n_cap++;
    end
    check_val("short_exec_cnt", n_exec, 12);
    check_val("short_cap_cnt", n_cap, 1);
    check_val("short_xpos", x_pos_o, 1);

    // Single write during EXEC is applied on the first idle cycle.
    run_i = 1'b1; tick();
    write(8'hA5, 1'b1);
    run_i = 1'b0;
    t_fall = -1; t_load = -1; prev = exec_o;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (prev && !exec_o && t_fall < 0) t_fall = i;
      if (mem_load_o && t_load < 0) t_load = i;
      prev = exec_o;
    end
    check_val("a5_load_seen", (t_load >= 0), 1);
    check_val("a5_load_gap", t_load - t_fall, 1);

    // Five writes into a depth-4 queue during one slot.
    pulse_frame();
    run_i = 1'b1; tick();
    write(8'h11, 1'b1); write(8'h12, 1'b1); write(8'h13, 1'b1); write(8'h14, 1'b1);
    check_val("ovf_before_drop", overflow_o, 0);
    write(8'h15, 1'b0);
    check_val("ovf_after_drop", overflow_o, 1);
    run_i = 1'b0;
    wait_drain("ovf_drain");
    check_val("ovf_sticky", overflow_o, 1);
`ifdef SHADER_SEQ_DROP_CNT_EN
    check_val("drop_cnt_1", drop_cnt_o, 1);
`endif
    pulse_frame();
    check_val("ovf_frame_clr", overflow_o, 0);
`ifdef SHADER_SEQ_DROP_CNT_EN
    check_val("drop_cnt_kept", drop_cnt_o, 1);
`endif

    // Push into a full queue in the same cycle as a pop is accepted.
    run_i = 1'b1; tick();
    write(8'h21, 1'b1); write(8'h22, 1'b1); write(8'h23, 1'b1); write(8'h24, 1'b1);
    run_i = 1'b0;
    wait_idle("pp_idle");
    write(8'h66, 1'b1);
    check_val("pp_load_now", mem_load_o, 1);
    check_val("pp_no_ovf", overflow_o, 0);
    wait_drain("pp_drain");

    // run_i in IDLE wins over a pending load.
    run_i = 1'b1; tick();
    write(8'h77, 1'b1);
    run_i = 1'b0;
    wait_idle("rb_idle");
    run_i = 1'b1; tick(); run_i = 1'b0;
    check_val("rb_no_load", mem_load_o, 0);
    check_val("rb_exec", exec_o, 1);
    wait_drain("rb_drain");

    // Drop in the same cycle as next_frame_i leaves overflow set.
    run_i = 1'b1; tick();
    write(8'h31, 1'b1); write(8'h32, 1'b1); write(8'h33, 1'b1); write(8'h34, 1'b1);
    next_frame_i = 1'b1;
    write(8'h35, 1'b0);
    next_frame_i = 1'b0;
    check_val("ovf_frame_same", overflow_o, 1);
    run_i = 1'b0;
    wait_drain("fs_drain");
`ifdef SHADER_SEQ_DROP_CNT_EN
    check_val("drop_cnt_2", drop_cnt_o, 2);
`endif

    // Coarse y.
    pulse_frame();
    for (int i = 0; i < 11; i++) pulse_line(1'b1);
    check_val("y_after_11", y_pos_o, 0);
    pulse_line(1'b1);
    check_val("y_after_12", y_pos_o, 1);
    for (int i = 0; i < 12; i++) pulse_line(1'b0);
    check_val("y_invisible", y_pos_o, 1);
    for (int i = 0; i < 5; i++) pulse_line(1'b1);
    pulse_frame();
    check_val("y_frame_clr", y_pos_o, 0);
    for (int i = 0; i < 11; i++) pulse_line(1'b1);
    check_val("y_sub_clr_11", y_pos_o, 0);
    pulse_line(1'b1);
    check_val("y_sub_clr_12", y_pos_o, 1);

    tick(); tick();
    check_val("queue_empty_end", load_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
